// File: rtl/sparse_tok_pkg.sv
// Shared token definitions for the sparse coordinate pipeline.
// Token: bit16=0 data in [15:0]; bit16=1 control, [9:8]=01 DONE, [9:8]=00 STOP with level in [7:0].
package sparse_tok_pkg;

  localparam int unsigned DATA_W     = 17;
  localparam int unsigned CTRL_BIT   = 16;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic [DATA_W-1:0] DONE_TOK = 17'h10100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } isect_state_e;

  // Coordinate/position pair stored jointly in each input FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] coord;
    logic [DATA_W-1:0] pos;
  } crd_pos_t;

  function automatic logic is_ctrl(input logic [DATA_W-1:0] tok);
    return tok[CTRL_BIT];
  endfunction

  function automatic logic is_stop(input logic [DATA_W-1:0] tok);
    return tok[CTRL_BIT] && (tok[9:8] == 2'b00);
  endfunction

  function automatic logic is_done(input logic [DATA_W-1:0] tok);
    return tok[CTRL_BIT] && (tok[9:8] == 2'b01);
  endfunction

  function automatic logic [7:0] stop_level(input logic [DATA_W-1:0] tok);
    return tok[7:0];
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Small register FIFO with same-cycle push/pop (a pop frees space for a push when full).
// Ports: clk, rst_n (async active-low), clk_en (hold), flush (sync clear),
//        push/din, pop/dout (head), full, empty.
module reg_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = clk_en & pop & ~empty;
  assign do_push = clk_en & push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/crd_intersect.sv
// Two-input sparse fiber intersector: emits common coordinates with the matching
// position from each input; STOP/DONE tokens are aligned and forwarded.
// Ports: clk, rst_n, clk_en, flush, tile_en;
//        coord_in_{0,1}/pos_in_{0,1} valid/ready inputs (paired per side);
//        coord_out, pos_out_{0,1} valid/ready outputs; proto_err (sticky).
module crd_intersect
  import sparse_tok_pkg::*;
#(
  parameter int unsigned DATA_W     = 17,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] coord_in_0,
  input  logic              coord_in_0_valid,
  output logic              coord_in_0_ready,
  input  logic [DATA_W-1:0] coord_in_1,
  input  logic              coord_in_1_valid,
  output logic              coord_in_1_ready,
  input  logic [DATA_W-1:0] pos_in_0,
  input  logic              pos_in_0_valid,
  output logic              pos_in_0_ready,
  input  logic [DATA_W-1:0] pos_in_1,
  input  logic              pos_in_1_valid,
  output logic              pos_in_1_ready,
  output logic [DATA_W-1:0] coord_out,
  output logic              coord_out_valid,
  input  logic              coord_out_ready,
  output logic [DATA_W-1:0] pos_out_0,
  output logic              pos_out_0_valid,
  input  logic              pos_out_0_ready,
  output logic [DATA_W-1:0] pos_out_1,
  output logic              pos_out_1_valid,
  input  logic              pos_out_1_ready,
  output logic              proto_err
);

  localparam int unsigned PAIR_W = $bits(crd_pos_t);
  localparam int unsigned VAL_W  = CTRL_BIT;

  isect_state_e state_q, state_d;
  logic         proto_err_q;
  logic         live_q;

  crd_pos_t in0_din, in1_din, in0_head, in1_head;
  logic     in0_full, in0_empty, in1_full, in1_empty;
  logic     in0_push, in1_push, pop0, pop1, accept_en;

  logic [DATA_W-1:0] oc_din, o0_din, o1_din;
  logic oc_full, oc_empty, o0_full, o0_empty, o1_full, o1_empty;
  logic oc_pop, o0_pop, o1_pop, push_out, fire, err_set;

  logic [DATA_W-1:0] h0, h1;

  // Input side: readies held low for one cycle after reset/flush and while draining DONE.
  assign accept_en        = tile_en & live_q & (state_q == ST_RUN);
  assign coord_in_0_ready = ~in0_full & accept_en;
  assign pos_in_0_ready   = ~in0_full & accept_en;
  assign coord_in_1_ready = ~in1_full & accept_en;
  assign pos_in_1_ready   = ~in1_full & accept_en;
  assign in0_push         = coord_in_0_valid & pos_in_0_valid & coord_in_0_ready;
  assign in1_push         = coord_in_1_valid & pos_in_1_valid & coord_in_1_ready;
  assign in0_din          = '{coord: coord_in_0, pos: pos_in_0};
  assign in1_din          = '{coord: coord_in_1, pos: pos_in_1};
  assign h0               = in0_head.coord;
  assign h1               = in1_head.coord;

  // Output side: each FIFO drains on its own ready.
  assign coord_out_valid = ~oc_empty & tile_en;
  assign pos_out_0_valid = ~o0_empty & tile_en;
  assign pos_out_1_valid = ~o1_empty & tile_en;
  assign oc_pop          = coord_out_valid & coord_out_ready;
  assign o0_pop          = pos_out_0_valid & pos_out_0_ready;
  assign o1_pop          = pos_out_1_valid & pos_out_1_ready;
  assign proto_err       = proto_err_q;

  // A same-cycle output pop counts as space.
  assign fire = ~in0_empty & ~in1_empty & (~oc_full | oc_pop) & (~o0_full | o0_pop) &
                (~o1_full | o1_pop) & clk_en & tile_en & (state_q == ST_RUN);

  reg_fifo #(.WIDTH(PAIR_W), .DEPTH(FIFO_DEPTH)) u_in0 (
    .clk, .rst_n, .clk_en, .flush, .push(in0_push), .din(in0_din), .pop(pop0),
    .dout(in0_head), .full(in0_full), .empty(in0_empty));
  reg_fifo #(.WIDTH(PAIR_W), .DEPTH(FIFO_DEPTH)) u_in1 (
    .clk, .rst_n, .clk_en, .flush, .push(in1_push), .din(in1_din), .pop(pop1),
    .dout(in1_head), .full(in1_full), .empty(in1_empty));
  reg_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_oc (
    .clk, .rst_n, .clk_en, .flush, .push(push_out), .din(oc_din), .pop(oc_pop),
    .dout(coord_out), .full(oc_full), .empty(oc_empty));
  reg_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_o0 (
    .clk, .rst_n, .clk_en, .flush, .push(push_out), .din(o0_din), .pop(o0_pop),
    .dout(pos_out_0), .full(o0_full), .empty(o0_empty));
  reg_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_o1 (
    .clk, .rst_n, .clk_en, .flush, .push(push_out), .din(o1_din), .pop(o1_pop),
    .dout(pos_out_1), .full(o1_full), .empty(o1_empty));

  // State, sticky error and post-reset arming register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      proto_err_q <= 1'b0;
      live_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_RUN;
      proto_err_q <= 1'b0;
      live_q      <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (err_set) proto_err_q <= 1'b1;
    end
  end

  // Head decision and next state.
  always_comb begin
    state_d  = state_q;
    pop0     = 1'b0;
    pop1     = 1'b0;
    push_out = 1'b0;
    err_set  = 1'b0;
    oc_din   = h0;
    o0_din   = h0;
    o1_din   = h0;
    unique case (state_q)
      ST_RUN: begin
        if (fire) begin
          if (!is_ctrl(h0) && !is_ctrl(h1)) begin
            if (h0[VAL_W-1:0] == h1[VAL_W-1:0]) begin
              push_out = 1'b1;
              o0_din   = in0_head.pos;
              o1_din   = in1_head.pos;
              pop0     = 1'b1;
              pop1     = 1'b1;
            end else if (h0[VAL_W-1:0] < h1[VAL_W-1:0]) begin
              pop0 = 1'b1;
            end else begin
              pop1 = 1'b1;
            end
          end else if (!is_ctrl(h0)) begin
            pop0 = 1'b1;
          end else if (!is_ctrl(h1)) begin
            pop1 = 1'b1;
          end else if (is_done(h0) && is_done(h1)) begin
            push_out = 1'b1;
            oc_din   = DONE_TOK;
            o0_din   = DONE_TOK;
            o1_din   = DONE_TOK;
            pop0     = 1'b1;
            pop1     = 1'b1;
            state_d  = ST_DONE;
          end else if (is_done(h0)) begin
            pop1 = 1'b1;
          end else if (is_done(h1)) begin
            pop0 = 1'b1;
          end else begin
            // Both STOP: input 0's level wins, a mismatch is flagged.
            push_out = 1'b1;
            pop0     = 1'b1;
            pop1     = 1'b1;
            err_set  = (stop_level(h0) != stop_level(h1)) | ~is_stop(h0) | ~is_stop(h1);
          end
        end
      end
      ST_DONE: begin
        if (oc_empty && o0_empty && o1_empty) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_crd_intersect.sv
module tb_crd_intersect;

  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] DN = 17'h10100;
  localparam logic [16:0] T1_C [4] = '{17'd3, 17'd5, 17'h10000, 17'h10100};
  localparam logic [16:0] T1_P [4] = '{17'd1, 17'd2, 17'h10000, 17'h10100};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        tile_en = 1'b1;
  logic [16:0] coord_in_0 = '0, coord_in_1 = '0, pos_in_0 = '0, pos_in_1 = '0;
  logic        coord_in_0_valid = 1'b0, coord_in_1_valid = 1'b0;
  logic        pos_in_0_valid = 1'b0, pos_in_1_valid = 1'b0;
  logic        coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
  logic [16:0] coord_out, pos_out_0, pos_out_1;
  logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
  logic        coord_out_ready = 1'b1, pos_out_0_ready = 1'b1, pos_out_1_ready = 1'b1;
  logic        proto_err;

  always #5 clk = ~clk;

  crd_intersect dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
    .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
    .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
    .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
    .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
    .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready),
    .proto_err(proto_err));

  logic [16:0] src0_c[$], src0_p[$], src1_c[$], src1_p[$];
  logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];
  logic        exp_err = 1'b0;
  int          checks = 0, fails = 0, cyc = 0, rdy_mode = 0;
  int          idx0 = 0, idx1 = 0;
  bit          gap_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Append a token; data positions are the data index within the current tile.
  task automatic add(input int side, input logic [16:0] tok);
    if (side == 0) begin
      src0_c.push_back(tok);
      src0_p.push_back(tok[16] ? tok : 17'(idx0));
      if (!tok[16]) idx0++;
      if (tok == DN) idx0 = 0;
    end else begin
      src1_c.push_back(tok);
      src1_p.push_back(tok[16] ? tok : 17'(idx1));
      if (!tok[16]) idx1++;
      if (tok == DN) idx1 = 0;
    end
  endtask

  task automatic load_tile1();
    add(0, 17'd1); add(0, 17'd3); add(0, 17'd5); add(0, S0); add(0, DN);
    add(1, 17'd2); add(1, 17'd3); add(1, 17'd5); add(1, S0); add(1, DN);
  endtask

  // Reference: split both streams at control tokens, intersect each segment as a
  // set (in input-0 order), then emit input 0's control token on all outputs.
  task automatic model();
    int i = 0, j = 0;
    logic [16:0] m [int];
    logic [16:0] a, b;
    while (i < src0_c.size() && j < src1_c.size()) begin
      m.delete();
      while (j < src1_c.size() && !src1_c[j][16]) begin
        m[int'(src1_c[j][15:0])] = src1_p[j];
        j++;
      end
      while (i < src0_c.size() && !src0_c[i][16]) begin
        if (m.exists(int'(src0_c[i][15:0]))) begin
          exp_c.push_back(src0_c[i]);
          exp_p0.push_back(src0_p[i]);
          exp_p1.push_back(m[int'(src0_c[i][15:0])]);
        end
        i++;
      end
      if (i < src0_c.size() && j < src1_c.size()) begin
        a = src0_c[i];
        b = src1_c[j];
        exp_c.push_back(a);
        exp_p0.push_back(a);
        exp_p1.push_back(a);
        if (a[7:0] != b[7:0]) exp_err = 1'b1;
        i++;
        j++;
      end
    end
  endtask

  task automatic gen_random_tile();
    int nseg = $urandom_range(1, 3);
    logic [15:0] base = ($urandom_range(0, 1) == 1) ? 16'hF000 : 16'h0000;
    logic [7:0] lvl;
    for (int s = 0; s < nseg; s++) begin
      for (int v = 0; v < 24; v++) begin
        if ($urandom_range(0, 2) == 0) add(0, {1'b0, base + 16'(v)});
        if ($urandom_range(0, 2) == 0) add(1, {1'b0, base + 16'(v)});
      end
      lvl = 8'($urandom_range(0, 2));
      add(0, {9'h100, lvl});
      add(1, {9'h100, lvl});
    end
    add(0, DN);
    add(1, DN);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(posedge clk);
      if (src0_c.size() == 0 && src1_c.size() == 0 && exp_c.size() == 0 &&
          exp_p0.size() == 0 && exp_p1.size() == 0) break;
    end
    if (k == 4000) begin
      fails++;
      checks++;
      $display("FAIL %s_timeout: got %0d/%0d/%0d tokens pending expected 0", name,
               exp_c.size(), exp_p0.size(), exp_p1.size());
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic clear_all();
    src0_c.delete(); src0_p.delete(); src1_c.delete(); src1_p.delete();
    exp_c.delete(); exp_p0.delete(); exp_p1.delete();
    idx0 = 0;
    idx1 = 0;
    exp_err = 1'b0;
  endtask

  task automatic out_check(input string name, input logic [16:0] act, inout logic [16:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s_unexpected: got %h expected no token", name, act);
    end else begin
      check(name, 32'(act), 32'(q.pop_front()));
    end
  endtask

  // Drive on the falling edge, sample handshakes just before the rising edge.
  initial begin : engine
    forever begin
      @(negedge clk);
      cyc++;
      coord_in_0_valid = (src0_c.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
      pos_in_0_valid   = (src0_c.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
      coord_in_0       = (src0_c.size() > 0) ? src0_c[0] : '0;
      pos_in_0         = (src0_p.size() > 0) ? src0_p[0] : '0;
      coord_in_1_valid = (src1_c.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
      pos_in_1_valid   = (src1_c.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
      coord_in_1       = (src1_c.size() > 0) ? src1_c[0] : '0;
      pos_in_1         = (src1_p.size() > 0) ? src1_p[0] : '0;
      clk_en           = !gap_mode || ($urandom_range(0, 7) != 0);
      case (rdy_mode)
        1: begin
          coord_out_ready = 1'b1;
          pos_out_0_ready = 1'b1;
          pos_out_1_ready = ((cyc / 2) % 2) == 1;
        end
        2: begin
          coord_out_ready = $urandom_range(0, 2) != 0;
          pos_out_0_ready = $urandom_range(0, 2) != 0;
          pos_out_1_ready = $urandom_range(0, 2) != 0;
        end
        default: begin
          coord_out_ready = 1'b1;
          pos_out_0_ready = 1'b1;
          pos_out_1_ready = 1'b1;
        end
      endcase
      #4;
      if (rst_n && !flush) begin
        if (clk_en && coord_in_0_valid && pos_in_0_valid && coord_in_0_ready && src0_c.size() > 0) begin
          void'(src0_c.pop_front());
          void'(src0_p.pop_front());
        end
        if (clk_en && coord_in_1_valid && pos_in_1_valid && coord_in_1_ready && src1_c.size() > 0) begin
          void'(src1_c.pop_front());
          void'(src1_p.pop_front());
        end
        if (clk_en && coord_out_valid && coord_out_ready) out_check("coord_out", coord_out, exp_c);
        if (clk_en && pos_out_0_valid && pos_out_0_ready) out_check("pos_out_0", pos_out_0, exp_p0);
        if (clk_en && pos_out_1_valid && pos_out_1_ready) out_check("pos_out_1", pos_out_1, exp_p1);
        // A DONE still queued means the tile has not drained: no new input may be taken.
        if (coord_out_valid && coord_out == DN) begin
          check("done_drain_rdy0", 32'(coord_in_0_ready), 32'd0);
          check("done_drain_rdy1", 32'(coord_in_1_ready), 32'd0);
        end
      end
    end
  end

  initial begin : main
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_coord_out_valid", 32'(coord_out_valid), 32'd0);
    check("rst_pos_out_0_valid", 32'(pos_out_0_valid), 32'd0);
    check("rst_pos_out_1_valid", 32'(pos_out_1_valid), 32'd0);
    check("rst_coord_in_0_ready", 32'(coord_in_0_ready), 32'd0);
    check("rst_pos_in_1_ready", 32'(pos_in_1_ready), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_coord_in_0_ready", 32'(coord_in_0_ready), 32'd1);
    check("idle_pos_in_1_ready", 32'(pos_in_1_ready), 32'd1);

    // Basic intersection, model pinned to hand-derived values
    load_tile1();
    model();
    check("t1_model_len", 32'(exp_c.size()), 32'd4);
    for (int i = 0; i < 4 && i < exp_c.size(); i++) begin
      check("t1_model_coord", 32'(exp_c[i]), 32'(T1_C[i]));
      check("t1_model_pos0", 32'(exp_p0[i]), 32'(T1_P[i]));
      check("t1_model_pos1", 32'(exp_p1[i]), 32'(T1_P[i]));
    end
    wait_idle("tile1");
    check("t1_proto_err", 32'(proto_err), 32'd0);

    // Disjoint fibers
    add(0, 17'd0); add(0, 17'd2); add(0, S0); add(0, DN);
    add(1, 17'd1); add(1, 17'd3); add(1, S0); add(1, DN);
    model();
    check("disjoint_model_len", 32'(exp_c.size()), 32'd2);
    wait_idle("disjoint");

    // Backpressure on pos_out_1
    rdy_mode = 1;
    load_tile1();
    model();
    wait_idle("backpressure");
    rdy_mode = 0;

    // STOP level mismatch
    add(0, S1); add(0, DN);
    add(1, S0); add(1, DN);
    model();
    check("mismatch_model_tok", 32'(exp_c[0]), 32'h10001);
    check("mismatch_model_err", 32'(exp_err), 32'd1);
    wait_idle("mismatch");
    check("mismatch_proto_err", 32'(proto_err), 32'(exp_err));
    repeat (5) @(negedge clk);
    #1;
    check("mismatch_sticky", 32'(proto_err), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_clears_err", 32'(proto_err), 32'd0);
    exp_err = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back tiles: an empty tile then the basic stream
    add(0, DN); add(1, DN);
    load_tile1();
    model();
    check("b2b_model_len", 32'(exp_c.size()), 32'd5);
    wait_idle("back_to_back");

    // Randomized tiles with gaps, random readies and clock-enable holes
    gap_mode = 1'b1;
    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      gen_random_tile();
      model();
      wait_idle("random");
      check("random_proto_err", 32'(proto_err), 32'(exp_err));
    end
    gap_mode = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    // Reset asserted mid-stream after two matches
    load_tile1();
    model();
    for (k = 0; k < 500 && exp_c.size() > 2; k++) @(posedge clk);
    check("midrst_reached_two_matches", 32'(exp_c.size() <= 2), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_coord_out_valid", 32'(coord_out_valid), 32'd0);
    check("midrst_pos_out_0_valid", 32'(pos_out_0_valid), 32'd0);
    check("midrst_pos_out_1_valid", 32'(pos_out_1_valid), 32'd0);
    check("midrst_coord_in_1_ready", 32'(coord_in_1_ready), 32'd0);
    clear_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_tile1();
    model();
    wait_idle("after_reset");
    check("after_reset_proto_err", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
